// File: rtl/data_port_arbiter_pkg.sv
// Shared types for the unified-memory data port arbiter.
// Read tags travel alongside each read through the RAM latency.
package rv32_mem_pkg;

  typedef enum logic {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int MEM_WORD_BYTES = 4;

endpackage

// File: rtl/data_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and RAM port B.
// slave is the arbiter's view, master the surrounding system's.
interface data_port_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              req0_i;
  logic              req1_i;
  logic [31:0]       addr0_i;
  logic [31:0]       addr1_i;
  logic [3:0]        we0_i;
  logic [3:0]        we1_i;
  logic [31:0]       wdata0_i;
  logic [31:0]       wdata1_i;
  logic              gnt0_o;
  logic              gnt1_o;
  logic              rvalid0_o;
  logic              rvalid1_o;
  logic [31:0]       rdata0_o;
  logic [31:0]       rdata1_o;
  logic              err0_o;
  logic              err1_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_we_o;
  logic [31:0]       mem_din_o;
  logic [31:0]       mem_dout_i;

  modport slave (
    input  req0_i, req1_i,
    input  addr0_i, addr1_i,
    input  we0_i, we1_i,
    input  wdata0_i, wdata1_i,
    input  mem_dout_i,
    output gnt0_o, gnt1_o,
    output rvalid0_o, rvalid1_o,
    output rdata0_o, rdata1_o,
    output err0_o, err1_o,
    output mem_addr_o, mem_we_o,
    output mem_din_o
  );

  modport master (
    output req0_i, req1_i,
    output addr0_i, addr1_i,
    output we0_i, we1_i,
    output wdata0_i, wdata1_i,
    output mem_dout_i,
    input  gnt0_o, gnt1_o,
    input  rvalid0_o, rvalid1_o,
    input  rdata0_o, rdata1_o,
    input  err0_o, err1_o,
    input  mem_addr_o, mem_we_o,
    input  mem_din_o
  );

endinterface

// File: rtl/data_port_arbiter_rd_tag_pipe.sv
// Shift register of read tags, one stage per RAM read-latency cycle.
// Synchronous clear drops every in-flight tag.
module rd_tag_pipe
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;
  rd_tag_t [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/data_port_arbiter.sv
// Two-requester arbiter for the data port of the unified memory.
// Core has priority; the loader is forced through after MAX_WAIT losses.
module data_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  data_port_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BO     = $clog2(MEM_WORD_BYTES);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(MAX_WAIT);

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              force1;
  logic              oor;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_we;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  always_comb begin
    force1  = bus.req1_i && (wait_q == WAIT_MAX);
    gnt0    = !rst_i && bus.req0_i && !force1;
    gnt1    = !rst_i && bus.req1_i
              && (!bus.req0_i || force1);
    any_gnt = gnt0 || gnt1;

    sel_addr  = gnt1 ? bus.addr1_i  : bus.addr0_i;
    sel_we    = gnt1 ? bus.we1_i    : bus.we0_i;
    sel_wdata = gnt1 ? bus.wdata1_i : bus.wdata0_i;
    oor       = |sel_addr[31:ADDR_W+BO];

    wait_d = wait_q;
    if (!bus.req1_i || gnt1) begin
      wait_d = '0;
    end else if (gnt0 && wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end

    // Idle cycles keep presenting the last address to the RAM.
    addr_d = any_gnt ? sel_addr[ADDR_W+BO-1:BO] : addr_q;

    tag_in.valid = any_gnt && !oor && (sel_we == 4'b0000);
    tag_in.owner = gnt1 ? OWN_LOADER : OWN_CORE;

    rvalid0_d = tag_out.valid && tag_out.owner == OWN_CORE;
    rvalid1_d = tag_out.valid && tag_out.owner == OWN_LOADER;
    rdata0_d  = rvalid0_d ? bus.mem_dout_i : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_dout_i : rdata1_q;

    err0_d = gnt0 && oor;
    err1_d = gnt1 && oor;
  end

  rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      addr_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign bus.gnt0_o     = gnt0;
  assign bus.gnt1_o     = gnt1;
  assign bus.rvalid0_o  = rvalid0_q;
  assign bus.rvalid1_o  = rvalid1_q;
  assign bus.rdata0_o   = rdata0_q;
  assign bus.rdata1_o   = rdata1_q;
  assign bus.err0_o     = err0_q;
  assign bus.err1_o     = err1_q;
  assign bus.mem_addr_o = addr_d;
  assign bus.mem_we_o   = (any_gnt && !oor) ? sel_we : 4'b0000;
  assign bus.mem_din_o  = any_gnt ? sel_wdata : 32'h0;

endmodule
